diff_stream_loader: RTL and testbench
=====================================

// Module: diff_stream_loader
// PURPOSE
//  Host-side transmitter for the core load interface. Consumes load descriptors
//  and a valid/ready DDR data stream, and drives the per-buffer address, write
//  enable and data lines into the core's fm/wt/bias buffers. It also issues the
//  core start handshake (core_valid/core_ready) and waits for core_finish.
//  It sits between the DDR read DMA and the core top.
// PARAMETERS
//  ADDR_W  12  buffer address width (clog2 of buffer depth); all three targets
//  DATA_W  64  stream word width, equal to the core stream_data input
//  LEN_W   16  descriptor length field width, in words
// PORTS
//  clk                input   1       clock
//  rst_n              input   1       async active-low reset
//  desc_valid         input   1       descriptor offered
//  desc_ready         output  1       descriptor accepted when valid&ready
//  desc_target        input   2       0=fm 1=wt 2=bias 3=start compute
//  desc_base          input   ADDR_W  first buffer address (ignored for target 3)
//  desc_len           input   LEN_W   number of words (ignored for target 3)
//  s_valid            input   1       stream word valid
//  s_ready            output  1       stream word accepted when valid&ready
//  s_data             input   DATA_W  stream word
//  fm_buf_addr_o      output  ADDR_W  fm buffer write address
//  wt_buf_addr_o      output  ADDR_W  wt buffer write address
//  bias_buf_addr_o    output  ADDR_W  bias buffer write address
//  fm_buf_wr_en_o     output  1       fm write strobe
//  wt_buf_wr_en_o     output  1       wt write strobe
//  bias_buf_wr_en_o   output  1       bias write strobe
//  stream_data_o      output  DATA_W  write data to core
//  core_valid_o       output  1       start request to core
//  core_ready_i       input   1       core accepts start
//  core_finish_i      input   1       core finished computation (pulse or level)
//  busy_o             output  1       state != IDLE
//  done_o             output  1       1-cycle pulse when a descriptor completes
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, counters 0. desc_ready is combinational (=IDLE).
//  FSM states: IDLE, LOAD, START, COMPUTE.
//   IDLE: desc_ready=1. On accept, latch target/base/len, then go to:
//    - START if target==3;
//    - IDLE if len==0 (done_o=1 next cycle, no writes);
//    - LOAD otherwise.
//   LOAD: s_ready=1 (combinational, state-only). Each s handshake produces a
//    registered write 1 cycle later: the selected wr_en_o=1, the selected
//    addr_o=base+k (k = 0..len-1), stream_data_o=s_data.
//    - Address wraps mod 2^ADDR_W, with no error.
//    - On the len-th handshake, go to IDLE; done_o pulses in the same cycle as
//      the last wr_en_o.
//    - s_valid low: no write, counters hold.
//   START: core_valid_o=1 (registered), held until core_ready_i is sampled 1.
//    Then core_valid_o=0 next cycle and go to COMPUTE.
//   COMPUTE: wait for core_finish_i=1, then done_o=1 and go to IDLE.
//    - core_finish_i is ignored in every other state.
//    - If finish arrives in the same cycle as ready, it is not counted.
//  Non-selected wr_en outputs stay 0; non-selected addr outputs hold 0.
//  stream_data_o holds its last value when no write is issued.
//  Only one descriptor is in flight at a time; no new desc while busy_o=1.
//  Stream words that arrive while not in LOAD are back-pressured (s_ready=0).
//  Reset asserted mid-operation: immediate return to reset values, partial
//   load abandoned; no done_o.
//  Internal counter width is LEN_W; len up to 2^LEN_W-1.
// TESTING
//  1 fm load, base=0x010, len=4, words A0..A3 back-to-back -> fm_buf_wr_en_o
//    4 cycles, addr 0x010..0x013, data A0..A3, done_o with last write.
//  2 wt load, len=3, s_valid toggles 1,0,1,0,1 -> exactly 3 wt writes, gaps
//    mirrored, fm/bias wr_en stay 0.
//  3 bias load, base=0xFFE, len=4 -> addrs 0xFFE,0xFFF,0x000,0x001.
//  4 len=0 fm descriptor -> no wr_en, done_o 1 cycle after accept, s_ready
//    never 1.
//  5 target=3, core_ready_i low 5 cycles, then high; core_finish_i 20 cycles
//    later -> core_valid_o high 6 cycles, done_o 1 cycle after finish;
//    finish pulse in IDLE -> no done_o.
//  6 rst_n low after 2 of 8 words loaded -> all outputs 0 asynchronously;
//    new descriptor accepted after release.

Source files
------------

// File: rtl/diff_stream_loader.sv
// Host-side loader: streams DDR words into the core fm/wt/bias buffers per descriptor
// and runs the core start/finish handshake for compute descriptors.
module diff_stream_loader #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [1:0]        desc_target,
  input  logic [ADDR_W-1:0] desc_base,
  input  logic [LEN_W-1:0]  desc_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic [ADDR_W-1:0] fm_buf_addr_o,
  output logic [ADDR_W-1:0] wt_buf_addr_o,
  output logic [ADDR_W-1:0] bias_buf_addr_o,
  output logic              fm_buf_wr_en_o,
  output logic              wt_buf_wr_en_o,
  output logic              bias_buf_wr_en_o,
  output logic [DATA_W-1:0] stream_data_o,
  output logic              core_valid_o,
  input  logic              core_ready_i,
  input  logic              core_finish_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [1:0] TGT_FM    = 2'd0;
  localparam logic [1:0] TGT_WT    = 2'd1;
  localparam logic [1:0] TGT_BIAS  = 2'd2;
  localparam logic [1:0] TGT_START = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOAD    = 2'd1,
    S_START   = 2'd2,
    S_COMPUTE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        target_q, target_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] fm_addr_q, fm_addr_d;
  logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
  logic [ADDR_W-1:0] bias_addr_q, bias_addr_d;
  logic              fm_we_q, fm_we_d;
  logic              wt_we_q, wt_we_d;
  logic              bias_we_q, bias_we_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              core_valid_q, core_valid_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] wr_addr;

  // Handshake readies depend on state only, so they never loop back through inputs.
  assign desc_ready = (state_q == S_IDLE);
  assign s_ready    = (state_q == S_LOAD);
  assign wr_addr    = base_q + ADDR_W'(cnt_q);

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    base_d       = base_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    fm_addr_d    = fm_addr_q;
    wt_addr_d    = wt_addr_q;
    bias_addr_d  = bias_addr_q;
    fm_we_d      = 1'b0;
    wt_we_d      = 1'b0;
    bias_we_d    = 1'b0;
    data_d       = data_q;
    core_valid_d = core_valid_q;
    done_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (desc_valid) begin
          target_d = desc_target;
          base_d   = desc_base;
          len_d    = desc_len;
          cnt_d    = '0;
          if (desc_target == TGT_START) begin
            state_d      = S_START;
            core_valid_d = 1'b1;
          end else if (desc_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          data_d      = s_data;
          cnt_d       = cnt_q + LEN_W'(1);
          // Only the buffer being written shows a live address; the others read 0.
          fm_addr_d   = '0;
          wt_addr_d   = '0;
          bias_addr_d = '0;
          case (target_q)
            TGT_FM: begin
              fm_we_d   = 1'b1;
              fm_addr_d = wr_addr;
            end
            TGT_WT: begin
              wt_we_d   = 1'b1;
              wt_addr_d = wr_addr;
            end
            TGT_BIAS: begin
              bias_we_d   = 1'b1;
              bias_addr_d = wr_addr;
            end
            default: ;
          endcase
          if (cnt_q == len_q - LEN_W'(1)) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      S_START: begin
        // Finish seen alongside ready is dropped: COMPUTE has not been entered yet.
        if (core_ready_i) begin
          core_valid_d = 1'b0;
          state_d      = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        if (core_finish_i) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      target_q     <= '0;
      base_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      fm_addr_q    <= '0;
      wt_addr_q    <= '0;
      bias_addr_q  <= '0;
      fm_we_q      <= 1'b0;
      wt_we_q      <= 1'b0;
      bias_we_q    <= 1'b0;
      data_q       <= '0;
      core_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      base_q       <= base_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      fm_addr_q    <= fm_addr_d;
      wt_addr_q    <= wt_addr_d;
      bias_addr_q  <= bias_addr_d;
      fm_we_q      <= fm_we_d;
      wt_we_q      <= wt_we_d;
      bias_we_q    <= bias_we_d;
      data_q       <= data_d;
      core_valid_q <= core_valid_d;
      done_q       <= done_d;
    end
  end

  assign fm_buf_addr_o    = fm_addr_q;
  assign wt_buf_addr_o    = wt_addr_q;
  assign bias_buf_addr_o  = bias_addr_q;
  assign fm_buf_wr_en_o   = fm_we_q;
  assign wt_buf_wr_en_o   = wt_we_q;
  assign bias_buf_wr_en_o = bias_we_q;
  assign stream_data_o    = data_q;
  assign core_valid_o     = core_valid_q;
  assign busy_o           = (state_q != S_IDLE);
  assign done_o           = done_q;

endmodule

// File: tb/tb_diff_stream_loader.sv
// Bench for diff_stream_loader: table vectors, hand-written start/reset sequences
// and randomized descriptors checked against a write-list reference model.
module tb_diff_stream_loader;
  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              desc_valid = 1'b0;
  logic              desc_ready;
  logic [1:0]        desc_target = '0;
  logic [ADDR_W-1:0] desc_base = '0;
  logic [LEN_W-1:0]  desc_len = '0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [DATA_W-1:0] s_data = '0;
  logic [ADDR_W-1:0] fm_buf_addr_o, wt_buf_addr_o, bias_buf_addr_o;
  logic              fm_buf_wr_en_o, wt_buf_wr_en_o, bias_buf_wr_en_o;
  logic [DATA_W-1:0] stream_data_o;
  logic              core_valid_o;
  logic              core_ready_i = 1'b0;
  logic              core_finish_i = 1'b0;
  logic              busy_o, done_o;

  diff_stream_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_target(desc_target),
    .desc_base(desc_base), .desc_len(desc_len),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .fm_buf_addr_o(fm_buf_addr_o), .wt_buf_addr_o(wt_buf_addr_o),
    .bias_buf_addr_o(bias_buf_addr_o), .fm_buf_wr_en_o(fm_buf_wr_en_o),
    .wt_buf_wr_en_o(wt_buf_wr_en_o), .bias_buf_wr_en_o(bias_buf_wr_en_o),
    .stream_data_o(stream_data_o), .core_valid_o(core_valid_o),
    .core_ready_i(core_ready_i), .core_finish_i(core_finish_i),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]        tgt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              done;
    int                cyc;
  } wr_t;

  typedef struct {
    logic [1:0]        tgt;
    logic [ADDR_W-1:0] base;
    int                len;
    int                mode;
    int                exp_n;
    logic [ADDR_W-1:0] exp_first;
    logic [ADDR_W-1:0] exp_last;
  } vec_t;

  wr_t obs_q[$];
  int  done_cnt = 0;
  int  cyc_n = 0;
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc_n++;

  // Write monitor: records every buffer write and counts done pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (done_o) done_cnt++;
      if (fm_buf_wr_en_o || wt_buf_wr_en_o || bias_buf_wr_en_o) begin
        wr_t w;
        check("wr_en_onehot", 64'(int'(fm_buf_wr_en_o) + int'(wt_buf_wr_en_o) + int'(bias_buf_wr_en_o)), 64'd1);
        w.tgt  = fm_buf_wr_en_o ? 2'd0 : (wt_buf_wr_en_o ? 2'd1 : 2'd2);
        w.addr = fm_buf_wr_en_o ? fm_buf_addr_o : (wt_buf_wr_en_o ? wt_buf_addr_o : bias_buf_addr_o);
        check("unselected_addr_zero",
              64'(fm_buf_wr_en_o ? (wt_buf_addr_o | bias_buf_addr_o) :
                  wt_buf_wr_en_o ? (fm_buf_addr_o | bias_buf_addr_o) :
                                   (fm_buf_addr_o | wt_buf_addr_o)), 64'd0);
        w.data = stream_data_o;
        w.done = done_o;
        w.cyc  = cyc_n;
        obs_q.push_back(w);
      end
    end
  end

  task automatic send_desc(input logic [1:0] tgt, input logic [ADDR_W-1:0] base,
                           input logic [LEN_W-1:0] len);
    bit ok = 1'b0;
    desc_valid = 1'b1; desc_target = tgt; desc_base = base; desc_len = len;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (desc_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    desc_valid = 1'b0;
    check("desc_accept", 64'(ok), 64'd1);
  endtask

  // mode 0: back-to-back, 1: valid toggles 1,0,1,..., 2: random valid
  task automatic run_load(input logic [1:0] tgt, input logic [ADDR_W-1:0] base, input int len,
                          input int mode, input string tag);
    wr_t               exp_q[$];
    int                d0;
    int                sent = 0;
    logic [DATA_W-1:0] word;
    obs_q.delete();
    d0 = done_cnt;
    send_desc(tgt, base, LEN_W'(len));
    if (len == 0) begin
      @(negedge clk);
      check({tag, "_len0_done"}, 64'(done_o), 64'd1);
      s_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_len0_s_ready"}, 64'(s_ready), 64'd0);
      end
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    word = {$urandom, $urandom};
    for (int cyc = 0; sent < len && cyc < len * 4 + 50; cyc++) begin
      bit v;
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : ($urandom_range(0, 2) != 0);
      s_valid = v; s_data = word;
      @(negedge clk);
      if (v && s_ready) begin
        exp_q.push_back('{tgt: tgt, addr: ADDR_W'(int'(base) + sent), data: word,
                          done: (sent == len - 1), cyc: cyc_n + 1});
        sent++;
        word = {$urandom, $urandom};
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_handshakes"}, 64'(sent), 64'(len));
    check({tag, "_nwrites"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      check({tag, "_tgt"}, 64'(obs_q[i].tgt), 64'(exp_q[i].tgt));
      check({tag, "_addr"}, 64'(obs_q[i].addr), 64'(exp_q[i].addr));
      check({tag, "_data"}, obs_q[i].data, exp_q[i].data);
      check({tag, "_done_with_write"}, 64'(obs_q[i].done), 64'(exp_q[i].done));
      check({tag, "_write_cycle"}, 64'(obs_q[i].cyc), 64'(exp_q[i].cyc));
    end
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_idle_after"}, 64'(busy_o), 64'd0);
  endtask

  task automatic run_start(input int rdy_dly, input int fin_dly, input bit fin_with_ready,
                           input string tag);
    int d0;
    int vcnt = 0;
    d0 = done_cnt;
    send_desc(2'd3, '0, '0);
    for (int i = 0; i < rdy_dly; i++) begin
      @(negedge clk);
      if (core_valid_o) vcnt++;
      @(posedge clk); #1;
    end
    core_ready_i = 1'b1; core_finish_i = fin_with_ready;
    @(negedge clk);
    if (core_valid_o) vcnt++;
    @(posedge clk); #1;
    core_ready_i = 1'b0; core_finish_i = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, 64'(core_valid_o), 64'd0);
    check({tag, "_valid_cycles"}, 64'(vcnt), 64'(rdy_dly + 1));
    check({tag, "_busy_compute"}, 64'(busy_o), 64'd1);
    for (int i = 0; i < fin_dly; i++) begin
      @(posedge clk); #1;
    end
    check({tag, "_no_early_done"}, 64'(done_cnt - d0), 64'd0);
    core_finish_i = 1'b1;
    @(posedge clk); #1;
    core_finish_i = 1'b0;
    @(negedge clk);
    check({tag, "_done"}, 64'(done_o), 64'd1);
    check({tag, "_idle"}, 64'(busy_o), 64'd0);
    @(posedge clk); #1;
    check({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_done_pulse"}, 64'(done_o), 64'd0);
  endtask

  vec_t vecs[5];

  initial begin
    int d0;
    vecs[0] = '{tgt: 2'd0, base: 12'h010, len: 4, mode: 0, exp_n: 4, exp_first: 12'h010, exp_last: 12'h013};
    vecs[1] = '{tgt: 2'd1, base: 12'h200, len: 3, mode: 1, exp_n: 3, exp_first: 12'h200, exp_last: 12'h202};
    vecs[2] = '{tgt: 2'd2, base: 12'hFFE, len: 4, mode: 0, exp_n: 4, exp_first: 12'hFFE, exp_last: 12'h001};
    vecs[3] = '{tgt: 2'd0, base: 12'h020, len: 0, mode: 0, exp_n: 0, exp_first: 12'h000, exp_last: 12'h000};
    vecs[4] = '{tgt: 2'd1, base: 12'hFFF, len: 1, mode: 0, exp_n: 1, exp_first: 12'hFFF, exp_last: 12'hFFF};

    #1;
    check("rst_busy", 64'(busy_o), 64'd0);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_wr_en", 64'({fm_buf_wr_en_o, wt_buf_wr_en_o, bias_buf_wr_en_o}), 64'd0);
    check("rst_data", stream_data_o, 64'd0);
    check("rst_core_valid", 64'(core_valid_o), 64'd0);
    check("rst_s_ready", 64'(s_ready), 64'd0);
    check("rst_desc_ready", 64'(desc_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) begin
      run_load(vecs[i].tgt, vecs[i].base, vecs[i].len, vecs[i].mode, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_count", i), 64'(obs_q.size()), 64'(vecs[i].exp_n));
      if (vecs[i].exp_n > 0 && obs_q.size() > 0) begin
        check($sformatf("vec%0d_first_addr", i), 64'(obs_q[0].addr), 64'(vecs[i].exp_first));
        check($sformatf("vec%0d_last_addr", i), 64'(obs_q[obs_q.size()-1].addr), 64'(vecs[i].exp_last));
      end
    end

    run_start(5, 20, 1'b0, "start");
    run_start(0, 3, 1'b1, "start_fin_with_ready");

    d0 = done_cnt;
    core_finish_i = 1'b1;
    @(posedge clk); #1;
    core_finish_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("idle_finish_ignored", 64'(done_cnt - d0), 64'd0);
    check("idle_finish_busy", 64'(busy_o), 64'd0);

    // Reset part-way through an 8-word load
    d0 = done_cnt;
    send_desc(2'd0, 12'h040, 16'd8);
    s_valid = 1'b1; s_data = 64'h1111_2222_3333_4444;
    @(posedge clk); #1;
    s_data = 64'h5555_6666_7777_8888;
    @(posedge clk); #1;
    s_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", 64'({fm_buf_wr_en_o, wt_buf_wr_en_o, bias_buf_wr_en_o}), 64'd0);
    check("midrst_addr", 64'({fm_buf_addr_o, wt_buf_addr_o, bias_buf_addr_o}), 64'd0);
    check("midrst_data", stream_data_o, 64'd0);
    check("midrst_busy", 64'(busy_o), 64'd0);
    check("midrst_s_ready", 64'(s_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    run_load(2'd0, 12'h050, 3, 0, "post_rst");

    for (int n = 0; n < 30; n++) begin
      int r;
      r = int'($urandom_range(0, 5));
      if (r == 5)
        run_start(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)),
                  $sformatf("rnd%0d_start", n));
      else
        run_load(2'(r % 3), 12'($urandom), int'($urandom_range(0, 10)), 2, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
